// File: rtl/ftf_decoder_33_if.sv
// Bus bundle for the 33-wire FTF decoder: codeword input side, decoded output side
// and the error counter. The decoder uses the slave view, the driving environment the master view.
interface ftf_decoder_33_if #(
  parameter int FBLEN33 = 23
);
  logic [32:0]        codein;
  logic               in_valid;
  logic               in_ready;
  logic [FBLEN33-1:0] dataout;
  logic               err;
  logic               out_valid;
  logic               out_ready;
  logic [15:0]        err_count;

  modport slave (
    input  codein, in_valid, out_ready,
    output in_ready, dataout, err, out_valid, err_count
  );

  modport master (
    output codein, in_valid, out_ready,
    input  in_ready, dataout, err, out_valid, err_count
  );
endinterface

// File: rtl/ftf_decoder_33.sv
// Three-stage pipelined decoder for 33-bit Fibonacci-weighted FTF codewords:
// weighted sum of set bits, range error flag, saturating error counter.
module ftf_decoder_33 (
  input  logic            clock,
  input  logic            rst_n,
  ftf_decoder_33_if.slave bus
);

  localparam int FBLEN33 = 23;
  localparam int SUM_W   = FBLEN33 + 1;
  localparam int NGRP    = 3;
  localparam int GRP_W   = 11;

  // Weight of codeword bit k is the Fibonacci number F(k+1), with F(1) = F(2) = 1.
  function automatic logic [SUM_W-1:0] weight(input int k);
    logic [SUM_W-1:0] a;
    logic [SUM_W-1:0] b;
    logic [SUM_W-1:0] t;
    a = SUM_W'(1);
    b = SUM_W'(1);
    for (int i = 2; i <= k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  logic                adv;
  logic                deliver;

  logic                s1_valid_q, s1_valid_d;
  logic [32:0]         s1_code_q,  s1_code_d;
  logic                s2_valid_q, s2_valid_d;
  logic [SUM_W-1:0]    psum_q [NGRP];
  logic [SUM_W-1:0]    psum_d [NGRP];
  logic                s3_valid_q, s3_valid_d;
  logic [FBLEN33-1:0]  dataout_q,  dataout_d;
  logic                err_q,      err_d;
  logic [15:0]         err_count_q, err_count_d;
  logic [SUM_W-1:0]    sum_full;

  // The whole pipe moves together; it only stops when a held output is refused.
  assign adv     = !s3_valid_q || bus.out_ready;
  assign deliver = s3_valid_q && bus.out_ready;

  // The three partial sums fit in SUM_W bits together, so this add never wraps.
  assign sum_full = psum_q[0] + psum_q[1] + psum_q[2];

  always_comb begin
    // NOTE: every next-state value defaults to its register first, so any path
    // that does not assign it holds state rather than inferring a latch.
    s1_valid_d = s1_valid_q;
    s1_code_d  = s1_code_q;
    s2_valid_d = s2_valid_q;
    s3_valid_d = s3_valid_q;
    dataout_d  = dataout_q;
    err_d      = err_q;
    for (int g = 0; g < NGRP; g++) begin
      psum_d[g] = psum_q[g];
    end

    if (adv) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_code_d = bus.codein;
      end

      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        for (int g = 0; g < NGRP; g++) begin
          psum_d[g] = '0;
          for (int b = 0; b < GRP_W; b++) begin
            if (s1_code_q[g*GRP_W + b]) begin
              psum_d[g] = psum_d[g] + weight(g*GRP_W + b);
            end
          end
        end
      end

      s3_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        dataout_d = sum_full[FBLEN33-1:0];
        err_d     = sum_full[FBLEN33];
      end
    end
  end

  always_comb begin
    err_count_d = err_count_q;
    if (deliver && err_q && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_code_q   <= '0;
      s2_valid_q  <= 1'b0;
      for (int g = 0; g < NGRP; g++) begin
        psum_q[g] <= '0;
      end
      s3_valid_q  <= 1'b0;
      dataout_q   <= '0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples its upstream
      // neighbour's pre-edge value and words shift exactly one stage per edge.
      s1_valid_q  <= s1_valid_d;
      s1_code_q   <= s1_code_d;
      s2_valid_q  <= s2_valid_d;
      for (int g = 0; g < NGRP; g++) begin
        psum_q[g] <= psum_d[g];
      end
      s3_valid_q  <= s3_valid_d;
      dataout_q   <= dataout_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = s3_valid_q;
  assign bus.dataout   = dataout_q;
  assign bus.err       = err_q;
  assign bus.err_count = err_count_q;

endmodule
